// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types.
//   char_t  : one 4-bit bus nibble
//   phase_t : the eight instruction-cycle phases A1..X3 (encoded 0..7)
//   PHASES  : number of phases per instruction cycle
package mcs4;

  typedef logic [3:0] char_t;

  localparam int PHASES = 8;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/mcs4_phase_tracker.sv
// Tracks the 8-phase MCS-4 instruction cycle from sync and clken_2.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clken_2           : one pulse per bus phase (a "step")
//   sync              : CPU cycle marker, expected on the X3 step
//   clr_err           : clears the sticky sync_err flag
//   phase, locked     : current phase and lock status (registered)
//   sync_err          : sticky, set on a misplaced or missing sync
//   step              : this clk is a step
//   cap_en            : this step is captured (step while locked)
//   cyc_done          : X3 step with sync while locked (cycle boundary)
//   cyc_full          : every phase A1..X3 of the ending cycle was seen locked
module mcs4_phase_tracker
  import mcs4::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clken_2,
  input  logic   sync,
  input  logic   clr_err,
  output phase_t phase,
  output logic   locked,
  output logic   sync_err,
  output logic   step,
  output logic   cap_en,
  output logic   cyc_done,
  output logic   cyc_full
);

  phase_t              phase_q, phase_d;
  logic                locked_q, locked_d;
  logic                sync_err_q, sync_err_d;
  logic [PHASES-1:0]   seen_q, seen_d;
  logic [PHASES-1:0]   seen_now;
  logic                sync_bad;

  always_comb begin
    phase_d   = phase_q;
    locked_d  = locked_q;
    seen_d    = seen_q;
    sync_bad  = 1'b0;
    cyc_done  = 1'b0;
    step      = clken_2;
    cap_en    = clken_2 & locked_q;
    // Phases visited since lock, including the one being stepped now.
    seen_now  = seen_q | (PHASES'(1) << phase_q);
    cyc_full  = &seen_now;

    if (clken_2) begin
      if (!locked_q) begin
        if (sync) begin
          phase_d  = A1;
          locked_d = 1'b1;
          seen_d   = '0;
        end
      end else if (phase_q == X3) begin
        phase_d = A1;
        seen_d  = '0;
        if (sync) begin
          cyc_done = 1'b1;
        end else begin
          sync_bad = 1'b1;
          locked_d = 1'b0;
        end
      end else if (sync) begin
        // Early sync: realign to A1 but keep lock.
        sync_bad = 1'b1;
        phase_d  = A1;
        seen_d   = '0;
      end else begin
        phase_d = next_phase(phase_q);
        seen_d  = seen_now;
      end
    end

    // A new sync error wins over a simultaneous clear.
    sync_err_d = sync_bad ? 1'b1 : (clr_err ? 1'b0 : sync_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= A1;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      seen_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      seen_q     <= seen_d;
    end
  end

  assign phase    = phase_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: rtl/mcs4_bus_hub.sv
// MCS-4 system data-bus hub: ORs N_DRV 4-bit drivers onto the shared bus,
// tracks the instruction cycle, captures address/OPR/OPA/command lines per
// cycle and flags driver contention and sync loss.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   clken_1            : phase-1 enable (not used internally)
//   clken_2            : phase-2 enable, one pulse per bus phase
//   sync               : CPU cycle marker
//   drv_in             : packed drivers, driver i at [4i+3:4i]
//   cm_rom, cm_ram     : ROM / RAM-bank command lines
//   clr_err            : clears contention, cont_mask, sync_err, cont_count
//   d_bus              : combinational OR of all drivers
//   phase, locked      : cycle tracker state
//   cyc_valid          : one-clk pulse, cyc_* fields hold a completed cycle
//   cyc_addr/opr/opa   : captured address and instruction nibbles
//   cyc_cm             : {cm_rom, cm_ram} sampled at the M2 step
//   contention         : sticky, more than one driver nonzero on a step
//   cont_mask          : nonzero drivers at the first contention
//   sync_err           : sticky sync loss flag
//   cyc_count          : completed cycles (wrapping)
//   cont_count         : contention steps (saturating)
module mcs4_bus_hub
  import mcs4::*;
#(
  parameter int N_DRV = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clken_1,
  input  logic               clken_2,
  input  logic               sync,
  input  logic [4*N_DRV-1:0] drv_in,
  input  logic               cm_rom,
  input  logic [3:0]         cm_ram,
  input  logic               clr_err,
  output logic [3:0]         d_bus,
  output logic [2:0]         phase,
  output logic               locked,
  output logic               cyc_valid,
  output logic [11:0]        cyc_addr,
  output logic [3:0]         cyc_opr,
  output logic [3:0]         cyc_opa,
  output logic [4:0]         cyc_cm,
  output logic               contention,
  output logic [N_DRV-1:0]   cont_mask,
  output logic               sync_err,
  output logic [CNT_W-1:0]   cyc_count,
  output logic [CNT_W-1:0]   cont_count
);

  logic unused_clken_1;
  assign unused_clken_1 = clken_1;

  phase_t trk_phase;
  logic   step, cap_en, cyc_done, cyc_full, complete;

  mcs4_phase_tracker u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken_2  (clken_2),
    .sync     (sync),
    .clr_err  (clr_err),
    .phase    (trk_phase),
    .locked   (locked),
    .sync_err (sync_err),
    .step     (step),
    .cap_en   (cap_en),
    .cyc_done (cyc_done),
    .cyc_full (cyc_full)
  );

  assign phase    = trk_phase;
  assign complete = cyc_done & cyc_full;

  char_t            bus;
  logic [N_DRV-1:0] nz_mask;
  logic             multi_drv;

  always_comb begin
    bus     = '0;
    nz_mask = '0;
    for (int i = 0; i < N_DRV; i++) begin
      bus        = bus | drv_in[4*i +: 4];
      nz_mask[i] = |drv_in[4*i +: 4];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_drv = |(nz_mask & (nz_mask - N_DRV'(1)));
  assign d_bus     = bus;

  logic [11:0]      addr_q, addr_d;
  char_t            opr_q, opr_d;
  char_t            opa_q, opa_d;
  logic [4:0]       cm_q, cm_d;
  logic             cyc_valid_q, cyc_valid_d;
  logic [11:0]      cyc_addr_q, cyc_addr_d;
  char_t            cyc_opr_q, cyc_opr_d;
  char_t            cyc_opa_q, cyc_opa_d;
  logic [4:0]       cyc_cm_q, cyc_cm_d;
  logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
  logic             contention_q, contention_d;
  logic [N_DRV-1:0] cont_mask_q, cont_mask_d;
  logic [CNT_W-1:0] cont_count_q, cont_count_d;

  always_comb begin
    addr_d = addr_q;
    opr_d  = opr_q;
    opa_d  = opa_q;
    cm_d   = cm_q;
    if (cap_en) begin
      case (trk_phase)
        A1: addr_d[3:0]  = bus;
        A2: addr_d[7:4]  = bus;
        A3: addr_d[11:8] = bus;
        M1: opr_d        = bus;
        M2: begin
          opa_d = bus;
          cm_d  = {cm_rom, cm_ram};
        end
        default: ;
      endcase
    end

    cyc_valid_d = complete;
    cyc_addr_d  = complete ? addr_q : cyc_addr_q;
    cyc_opr_d   = complete ? opr_q  : cyc_opr_q;
    cyc_opa_d   = complete ? opa_q  : cyc_opa_q;
    cyc_cm_d    = complete ? cm_q   : cyc_cm_q;
    cyc_count_d = cyc_count_q + CNT_W'(complete);

    // Clear first so that a contention in the same clk takes effect on top.
    contention_d = clr_err ? 1'b0 : contention_q;
    cont_mask_d  = clr_err ? '0   : cont_mask_q;
    cont_count_d = clr_err ? '0   : cont_count_q;
    if (step && multi_drv) begin
      if (cont_count_d != {CNT_W{1'b1}}) begin
        cont_count_d = cont_count_d + CNT_W'(1);
      end
      if (!contention_d) begin
        contention_d = 1'b1;
        cont_mask_d  = nz_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      opr_q        <= '0;
      opa_q        <= '0;
      cm_q         <= '0;
      cyc_valid_q  <= 1'b0;
      cyc_addr_q   <= '0;
      cyc_opr_q    <= '0;
      cyc_opa_q    <= '0;
      cyc_cm_q     <= '0;
      cyc_count_q  <= '0;
      contention_q <= 1'b0;
      cont_mask_q  <= '0;
      cont_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      opr_q        <= opr_d;
      opa_q        <= opa_d;
      cm_q         <= cm_d;
      cyc_valid_q  <= cyc_valid_d;
      cyc_addr_q   <= cyc_addr_d;
      cyc_opr_q    <= cyc_opr_d;
      cyc_opa_q    <= cyc_opa_d;
      cyc_cm_q     <= cyc_cm_d;
      cyc_count_q  <= cyc_count_d;
      contention_q <= contention_d;
      cont_mask_q  <= cont_mask_d;
      cont_count_q <= cont_count_d;
    end
  end

  assign cyc_valid  = cyc_valid_q;
  assign cyc_addr   = cyc_addr_q;
  assign cyc_opr    = cyc_opr_q;
  assign cyc_opa    = cyc_opa_q;
  assign cyc_cm     = cyc_cm_q;
  assign cyc_count  = cyc_count_q;
  assign contention = contention_q;
  assign cont_mask  = cont_mask_q;
  assign cont_count = cont_count_q;

endmodule
